// File: rtl/fft_peak_pick.sv
// Per-frame peak picker for the FFT output stream: reports the positive-frequency bin with the largest |re|+|im|.
// Optional FFT_PEAK_RANGE_EN adds search_lo/search_hi ports that narrow the candidate window per frame.
module fft_peak_pick #(
  parameter int FFT_N = 1024,
  parameter int BIN_W = 16
) (
  input  logic                    aclk,
  input  logic                    rst_n,
  input  logic signed [31:0]      fft_re,
  input  logic signed [31:0]      fft_im,
  input  logic                    fft_en,
  input  logic                    fft_last,
`ifdef FFT_PEAK_RANGE_EN
  input  logic [BIN_W-1:0]        search_lo,
  input  logic [BIN_W-1:0]        search_hi,
`endif
  output logic                    peak_valid,
  output logic [BIN_W-1:0]        peak_bin,
  output logic signed [31:0]      peak_re,
  output logic signed [31:0]      peak_im,
  output logic [32:0]             peak_mag,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_N - 1);
  localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(FFT_N / 2);
  localparam logic [BIN_W-1:0] ZERO_BIN = '0;

  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             at_last, frame_end;
  logic [31:0]      re_u, im_u, abs_re, abs_im;
  logic [32:0]      mag;
  logic             in_win, empty_win;

  logic               s1_valid_q, s1_cand_q, s1_end_q, s1_err_q;
  logic [32:0]        s1_mag_q;
  logic signed [31:0] s1_re_q, s1_im_q;
  logic [BIN_W-1:0]   s1_bin_q;

  logic               max_valid_q, max_valid_d;
  logic [32:0]        max_mag_q, max_mag_d;
  logic signed [31:0] max_re_q, max_re_d, max_im_q, max_im_d;
  logic [BIN_W-1:0]   max_bin_q, max_bin_d;

  logic               take, cur_valid;
  logic [32:0]        cur_mag;
  logic signed [31:0] cur_re, cur_im;
  logic [BIN_W-1:0]   cur_bin;

  logic               pk_valid_q, pk_valid_d, pk_err_q, pk_err_d;
  logic [BIN_W-1:0]   pk_bin_q, pk_bin_d;
  logic signed [31:0] pk_re_q, pk_re_d, pk_im_q, pk_im_d;
  logic [32:0]        pk_mag_q, pk_mag_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  // Bin counter and frame-end detection
  always_comb begin
    at_last   = (bin_cnt_q == LAST_BIN);
    frame_end = fft_last | at_last;
    bin_cnt_d = bin_cnt_q;
    if (fft_en) bin_cnt_d = frame_end ? ZERO_BIN : bin_cnt_q + 1'b1;
  end

  // |-2^31| must come out as 2^31, so negate in the unsigned domain
  always_comb begin
    re_u   = fft_re;
    im_u   = fft_im;
    abs_re = re_u[31] ? (~re_u + 32'd1) : re_u;
    abs_im = im_u[31] ? (~im_u + 32'd1) : im_u;
    mag    = {1'b0, abs_re} + {1'b0, abs_im};
  end

`ifdef FFT_PEAK_RANGE_EN
  logic [BIN_W-1:0] lo_q, hi_q, lim_lo, lim_hi;

  // Limits are captured on bin 0; bin 0 itself sees the live inputs
  always_comb begin
    lim_lo    = (bin_cnt_q == ZERO_BIN) ? search_lo : lo_q;
    lim_hi    = (bin_cnt_q == ZERO_BIN) ? search_hi : hi_q;
    empty_win = (lim_lo > lim_hi);
    in_win    = (bin_cnt_q != ZERO_BIN) && (bin_cnt_q < HALF_BIN) &&
                (bin_cnt_q >= lim_lo) && (bin_cnt_q <= lim_hi);
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (fft_en && (bin_cnt_q == ZERO_BIN)) begin
      lo_q <= search_lo;
      hi_q <= search_hi;
    end
  end
`else
  always_comb begin
    empty_win = 1'b0;
    in_win    = (bin_cnt_q != ZERO_BIN) && (bin_cnt_q < HALF_BIN);
  end
`endif

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_cand_q  <= 1'b0;
      s1_end_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_mag_q   <= '0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_bin_q   <= '0;
    end else begin
      bin_cnt_q  <= bin_cnt_d;
      s1_valid_q <= fft_en;
      if (fft_en) begin
        s1_cand_q <= in_win;
        s1_end_q  <= frame_end;
        s1_err_q  <= (fft_last ^ at_last) | empty_win;
        s1_mag_q  <= mag;
        s1_re_q   <= fft_re;
        s1_im_q   <= fft_im;
        s1_bin_q  <= bin_cnt_q;
      end
    end
  end

  // Compare stage: the frame-end beat folds its own candidate into the result
  // and clears the running max in the same cycle, so a back-to-back frame starts clean.
  always_comb begin
    take      = s1_valid_q && s1_cand_q && (!max_valid_q || (s1_mag_q > max_mag_q));
    cur_valid = max_valid_q | (s1_valid_q & s1_cand_q);
    cur_mag   = take ? s1_mag_q : max_mag_q;
    cur_re    = take ? s1_re_q  : max_re_q;
    cur_im    = take ? s1_im_q  : max_im_q;
    cur_bin   = take ? s1_bin_q : max_bin_q;

    max_valid_d = max_valid_q;
    max_mag_d   = max_mag_q;
    max_re_d    = max_re_q;
    max_im_d    = max_im_q;
    max_bin_d   = max_bin_q;
    pk_valid_d  = 1'b0;
    pk_err_d    = pk_err_q;
    pk_bin_d    = pk_bin_q;
    pk_re_d     = pk_re_q;
    pk_im_d     = pk_im_q;
    pk_mag_d    = pk_mag_q;
    frame_cnt_d = frame_cnt_q;

    if (s1_valid_q && s1_end_q) begin
      max_valid_d = 1'b0;
      max_mag_d   = '0;
      max_re_d    = '0;
      max_im_d    = '0;
      max_bin_d   = '0;
      pk_valid_d  = 1'b1;
      pk_err_d    = s1_err_q;
      pk_bin_d    = cur_valid ? cur_bin : ZERO_BIN;
      pk_re_d     = cur_valid ? cur_re  : 32'sd0;
      pk_im_d     = cur_valid ? cur_im  : 32'sd0;
      pk_mag_d    = cur_valid ? cur_mag : 33'd0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (take) begin
      max_valid_d = 1'b1;
      max_mag_d   = s1_mag_q;
      max_re_d    = s1_re_q;
      max_im_d    = s1_im_q;
      max_bin_d   = s1_bin_q;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      max_valid_q <= 1'b0;
      max_mag_q   <= '0;
      max_re_q    <= '0;
      max_im_q    <= '0;
      max_bin_q   <= '0;
      pk_valid_q  <= 1'b0;
      pk_err_q    <= 1'b0;
      pk_bin_q    <= '0;
      pk_re_q     <= '0;
      pk_im_q     <= '0;
      pk_mag_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      max_valid_q <= max_valid_d;
      max_mag_q   <= max_mag_d;
      max_re_q    <= max_re_d;
      max_im_q    <= max_im_d;
      max_bin_q   <= max_bin_d;
      pk_valid_q  <= pk_valid_d;
      pk_err_q    <= pk_err_d;
      pk_bin_q    <= pk_bin_d;
      pk_re_q     <= pk_re_d;
      pk_im_q     <= pk_im_d;
      pk_mag_q    <= pk_mag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign peak_valid = pk_valid_q;
  assign peak_bin   = pk_bin_q;
  assign peak_re    = pk_re_q;
  assign peak_im    = pk_im_q;
  assign peak_mag   = pk_mag_q;
  assign frame_err  = pk_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
